output_device_bank: RTL and testbench

Parametrised bank of memory-mapped output device registers with write modes, readback and a change-event queue. Sits on the CPU's output bus in place of the fixed two-device output block: the core writes a value to an 8-bit device address, the addressed register drives its device pins, and every write that changes a register value is queued as an event for a downstream consumer such as a serial console or debug tap.

---
 rtl/output_device_bank.sv | 136 +++++++++++++
 tb/tb_output_device_bank.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/output_device_bank.sv
// rtl/output_device_bank.sv - memory-mapped output device registers with write modes and a change-event FIFO
module output_device_bank #(
  parameter int NUM_DEVICES = 4,
  parameter int WIDTH       = 32,
  parameter int EVENT_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               address,
  input  logic [WIDTH-1:0]         value,
  input  logic [1:0]               write_mode,
  input  logic                     is_write,
  output logic [NUM_DEVICES*WIDTH-1:0] device_values,
  output logic [WIDTH-1:0]         read_value,
  output logic                     bad_address,
  output logic                     event_valid,
  output logic [7:0]               event_address,
  output logic [WIDTH-1:0]         event_value,
  input  logic                     event_ready,
  output logic                     event_overflow
);

  localparam int PTR_W = (EVENT_DEPTH > 1) ? $clog2(EVENT_DEPTH) : 1;
  localparam int EW    = 8 + WIDTH;
  localparam logic [PTR_W:0] FULL = EVENT_DEPTH[PTR_W:0];

  localparam logic [1:0] MODE_STORE  = 2'd0;
  localparam logic [1:0] MODE_SET    = 2'd1;
  localparam logic [1:0] MODE_CLEAR  = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;

  logic [WIDTH-1:0] regs_q [NUM_DEVICES];
  logic [WIDTH-1:0] regs_d [NUM_DEVICES];
  logic [EW-1:0]    mem_q  [EVENT_DEPTH];
  logic [EW-1:0]    mem_d  [EVENT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             bad_address_q, bad_address_d;
  logic             overflow_q, overflow_d;

  logic             in_range;
  logic [WIDTH-1:0] new_val;
  logic             change;
  logic             pop;
  logic             push;

  // Readback sees the pre-edge register contents; it doubles as the old value for writes
  always_comb begin
    read_value = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      if (address == 8'(i)) read_value = regs_q[i];
    end
  end

  always_comb begin
    device_values = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      device_values[i*WIDTH +: WIDTH] = regs_q[i];
    end
  end

  assign in_range = {1'b0, address} < NUM_DEVICES[8:0];

  always_comb begin
    new_val = value;
    case (write_mode)
      MODE_STORE:  new_val = value;
      MODE_SET:    new_val = read_value | value;
      MODE_CLEAR:  new_val = read_value & ~value;
      MODE_TOGGLE: new_val = read_value ^ value;
      default:     new_val = value;
    endcase
  end

  assign change = is_write && in_range && (new_val != read_value);
  assign pop    = (count_q != '0) && event_ready;
  // A full queue can still accept a push when the head leaves in the same cycle
  assign push   = change && ((count_q != FULL) || pop);

  always_comb begin
    regs_d        = regs_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    bad_address_d = is_write && !in_range;
    overflow_d    = overflow_q | (change && !push);

    if (is_write && in_range) begin
      for (int i = 0; i < NUM_DEVICES; i++) begin
        if (address == 8'(i)) regs_d[i] = new_val;
      end
    end

    if (push) begin
      mem_d[wr_ptr_q] = {address, new_val};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q        <= '{default: '0};
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      bad_address_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      regs_q        <= regs_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      bad_address_q <= bad_address_d;
      overflow_q    <= overflow_d;
    end
  end

  assign bad_address    = bad_address_q;
  assign event_valid    = count_q != '0;
  assign event_address  = mem_q[rd_ptr_q][EW-1:WIDTH];
  assign event_value    = mem_q[rd_ptr_q][WIDTH-1:0];
  assign event_overflow = overflow_q;

endmodule

// File: tb/tb_output_device_bank.sv
// tb/tb_output_device_bank.sv - directed self-checking bench for output_device_bank
module tb_output_device_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   address;
  logic [31:0]  value;
  logic [1:0]   write_mode;
  logic         is_write;
  logic [127:0] device_values;
  logic [31:0]  read_value;
  logic         bad_address;
  logic         event_valid;
  logic [7:0]   event_address;
  logic [31:0]  event_value;
  logic         event_ready;
  logic         event_overflow;

  int errors = 0;
  int checks = 0;

  output_device_bank #(.NUM_DEVICES(4), .WIDTH(32), .EVENT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .address(address), .value(value),
    .write_mode(write_mode), .is_write(is_write),
    .device_values(device_values), .read_value(read_value),
    .bad_address(bad_address), .event_valid(event_valid),
    .event_address(event_address), .event_value(event_value),
    .event_ready(event_ready), .event_overflow(event_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v, input logic [1:0] m);
    address = a; value = v; write_mode = m; is_write = 1'b1;
    tick();
    is_write = 1'b0;
  endtask

  task automatic pop_one();
    event_ready = 1'b1;
    tick();
    event_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (device_values !== 128'h0) begin errors++; $display("FAIL reset_dv got=%h exp=0", device_values); end
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", event_valid); end
    checks++; if (event_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", event_overflow); end
    checks++; if (bad_address !== 1'b0) begin errors++; $display("FAIL reset_bad got=%b exp=0", bad_address); end
  endtask

  task automatic test_store();
    logic [7:0]  ea [2] = '{8'd0, 8'd1};
    logic [31:0] ev [2] = '{32'hE5F84AB1, 32'h5C8C6A01};
    wr(8'd0, 32'hE5F84AB1, 2'd0);
    wr(8'd1, 32'h5C8C6A01, 2'd0);
    tick();
    address = 8'd0;
    #1;
    checks++; if (device_values[31:0] !== 32'hE5F84AB1) begin errors++; $display("FAIL store_dev0 got=%h exp=e5f84ab1", device_values[31:0]); end
    checks++; if (device_values[63:32] !== 32'h5C8C6A01) begin errors++; $display("FAIL store_dev1 got=%h exp=5c8c6a01", device_values[63:32]); end
    checks++; if (read_value !== 32'hE5F84AB1) begin errors++; $display("FAIL store_read0 got=%h exp=e5f84ab1", read_value); end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (event_valid !== 1'b1 || event_address !== ea[k] || event_value !== ev[k]) begin
        errors++; $display("FAIL store_event%0d got=%b/%0d/%h exp=1/%0d/%h", k, event_valid, event_address, event_value, ea[k], ev[k]);
      end
      pop_one();
    end
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL store_drained got=%b exp=0", event_valid); end
  endtask

  task automatic test_modes();
    logic [31:0] ev [3] = '{32'h000000FF, 32'h0000000F, 32'hFFFFFFF0};
    wr(8'd2, 32'h000000F0, 2'd0);
    pop_one();
    wr(8'd2, 32'h0000000F, 2'd1);
    checks++; if (device_values[95:64] !== 32'h000000FF) begin errors++; $display("FAIL mode_set got=%h exp=000000ff", device_values[95:64]); end
    wr(8'd2, 32'h000000F0, 2'd2);
    checks++; if (device_values[95:64] !== 32'h0000000F) begin errors++; $display("FAIL mode_clear got=%h exp=0000000f", device_values[95:64]); end
    wr(8'd2, 32'hFFFFFFFF, 2'd3);
    checks++; if (device_values[95:64] !== 32'hFFFFFFF0) begin errors++; $display("FAIL mode_toggle got=%h exp=fffffff0", device_values[95:64]); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (event_valid !== 1'b1 || event_address !== 8'd2 || event_value !== ev[k]) begin
        errors++; $display("FAIL mode_event%0d got=%b/%0d/%h exp=1/2/%h", k, event_valid, event_address, event_value, ev[k]);
      end
      pop_one();
    end
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL mode_drained got=%b exp=0", event_valid); end
  endtask

  task automatic test_no_change_and_bad();
    logic [127:0] snap;
    wr(8'd2, 32'h0000000F, 2'd0);
    pop_one();
    wr(8'd2, 32'h0000000F, 2'd0);
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL nochange_store got=%b exp=0", event_valid); end
    wr(8'd2, 32'h00000003, 2'd1);
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL nochange_set got=%b exp=0", event_valid); end
    snap = {32'h0, 32'h0000000F, 32'h5C8C6A01, 32'hE5F84AB1};
    wr(8'd9, 32'h12345678, 2'd0);
    checks++; if (bad_address !== 1'b1) begin errors++; $display("FAIL bad_pulse got=%b exp=1", bad_address); end
    checks++; if (device_values !== snap) begin errors++; $display("FAIL bad_regs got=%h exp=%h", device_values, snap); end
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL bad_event got=%b exp=0", event_valid); end
    tick();
    checks++; if (bad_address !== 1'b0) begin errors++; $display("FAIL bad_once got=%b exp=0", bad_address); end
  endtask

  task automatic test_full_pop();
    logic [31:0] ev [4] = '{32'h11, 32'h12, 32'h13, 32'h14};
    test_reset();
    for (int k = 0; k < 4; k++) wr(8'd0, 32'h10 + k, 2'd0);
    event_ready = 1'b1;
    wr(8'd0, 32'h14, 2'd0);
    event_ready = 1'b0;
    checks++; if (event_overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got=%b exp=0", event_overflow); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (event_valid !== 1'b1 || event_address !== 8'd0 || event_value !== ev[k]) begin
        errors++; $display("FAIL fullpop_event%0d got=%b/%0d/%h exp=1/0/%h", k, event_valid, event_address, event_value, ev[k]);
      end
      pop_one();
    end
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL fullpop_drained got=%b exp=0", event_valid); end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) wr(8'd3, 32'(k), 2'd0);
    checks++; if (event_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", event_overflow); end
    checks++; if (device_values[127:96] !== 32'd5) begin errors++; $display("FAIL ovf_reg got=%h exp=5", device_values[127:96]); end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (event_valid !== 1'b1 || event_address !== 8'd3 || event_value !== 32'(k)) begin
        errors++; $display("FAIL ovf_event%0d got=%b/%0d/%h exp=1/3/%h", k, event_valid, event_address, event_value, k);
      end
      pop_one();
    end
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", event_valid); end
    checks++; if (event_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", event_overflow); end
  endtask

  task automatic test_reset_midstream();
    wr(8'd0, 32'hA, 2'd0);
    wr(8'd1, 32'hB, 2'd0);
    wr(8'd2, 32'hC, 2'd0);
    reset = 1'b1;
    event_ready = 1'b1;
    wr(8'd1, 32'hDEAD, 2'd0);
    reset = 1'b0;
    event_ready = 1'b0;
    checks++; if (device_values !== 128'h0) begin errors++; $display("FAIL midreset_dv got=%h exp=0", device_values); end
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b exp=0", event_valid); end
    checks++; if (event_overflow !== 1'b0) begin errors++; $display("FAIL midreset_ovf got=%b exp=0", event_overflow); end
    tick();
    checks++; if (event_valid !== 1'b0 || device_values !== 128'h0) begin errors++; $display("FAIL midreset_hold got=%b/%h exp=0/0", event_valid, device_values); end
  endtask

  initial begin
    reset = 1'b1; address = '0; value = '0; write_mode = '0; is_write = 1'b0; event_ready = 1'b0;
    tick();
    test_reset();
    test_store();
    test_modes();
    test_no_change_and_bad();
    test_full_pop();
    test_overflow();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
